// File: rtl/obi_mem_arbiter_pkg.sv
// rtl/obi_mem_arbiter_pkg.sv - shared types and constants for the OBI memory arbiter
// Purpose: owner IDs, arbiter lock states and default constants shared by the
//          arbiter top, its owner FIFO and the testbench.
// Ports:   none (package).
package obi_arb_pkg;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } arb_state_e;

  localparam int DEFAULT_MAX_OUTSTANDING = 2;

  // Wide enough for any practical DATA_W/8; users slice the low bits.
  localparam logic [127:0] INSTR_BE_ALL = '1;

endpackage

// File: rtl/obi_mem_arbiter_if.sv
// rtl/obi_mem_arbiter_if.sv - bundle of fetch, LSU and downstream memory handshake signals
// Purpose: groups the instruction, data and downstream OBI-style signals.
// Modports:
//   slave  - arbiter view: takes fetch/LSU requests, drives the memory port.
//   master - environment view: drives fetch/LSU requests, answers as memory.
interface obi_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              instr_req_i;
  logic [ADDR_W-1:0] instr_addr_i;
  logic              instr_gnt_o;
  logic              instr_rvalid_o;
  logic [DATA_W-1:0] instr_rdata_o;

  logic              data_req_i;
  logic              data_we_i;
  logic [BE_W-1:0]   data_be_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [DATA_W-1:0] data_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

endinterface

// File: rtl/obi_mem_arbiter_owner_fifo.sv
// rtl/obi_mem_arbiter_owner_fifo.sv - in-order FIFO of owner IDs for outstanding transactions
// Purpose: records which requester owns each granted-but-unanswered transaction.
// Ports:
//   clock, reset       - clock, asynchronous active-high reset
//   push, push_data    - enqueue one owner bit
//   pop                - dequeue the head (legal when non-empty, or with a same-cycle push)
//   head_data          - current head; bypasses push_data while empty
//   full, empty, count - occupancy status
module obi_owner_fifo #(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          push_data,
  input  logic          pop,
  output logic          head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;
  logic             bypass, do_write, do_read;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;

  // A push and pop on an empty FIFO pass straight through without storage.
  assign bypass    = push & pop & empty;
  assign do_write  = push & ~bypass;
  assign do_read   = pop & ~empty;
  assign head_data = empty ? push_data : mem_q[rd_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_write) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_read) begin
        rd_q <= ptr_inc(rd_q);
      end
      case ({do_write, do_read})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// rtl/obi_mem_arbiter.sv - round-robin arbiter sharing one OBI memory port between fetch and LSU
// Purpose: selects fetch or LSU onto the downstream port, holds the selection
//          until grant, and routes each response back to its issuer in order.
// Ports:
//   clock, reset   - clock, asynchronous active-high reset
//   bus            - fetch, LSU and downstream memory signals (slave modport)
//   outstanding_o  - granted-but-unanswered transaction count
//   resp_err_o     - sticky flag: response seen with nothing outstanding
module obi_mem_arbiter
  import obi_arb_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter  int ADDR_W          = 32,
  parameter  int DATA_W          = 32,
  localparam int BE_W            = DATA_W / 8,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clock,
  input  logic             reset,
  obi_mem_arbiter_if.slave bus,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             resp_err_o
);

  arb_state_e state_q, state_d;
  owner_e     rr_q, sel, head_owner;
  logic       sel_req, can_issue, mem_req, grant;
  logic       fifo_full, fifo_empty, fifo_pop, fifo_head;
  logic       resp_err_q;

  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= OWNER_INSTR;
      resp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        rr_q <= (sel == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
      end
      if (bus.mem_rvalid_i && fifo_empty && !grant) begin
        resp_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel       = OWNER_INSTR;
    sel_req   = 1'b0;
    can_issue = 1'b0;
    mem_req   = 1'b0;
    grant     = 1'b0;

    case (state_q)
      LOCK_I:  sel = OWNER_INSTR;
      LOCK_D:  sel = OWNER_DATA;
      default: begin
        if (bus.instr_req_i && bus.data_req_i) sel = rr_q;
        else if (bus.data_req_i)               sel = OWNER_DATA;
        else                                   sel = OWNER_INSTR;
      end
    endcase

    sel_req   = (sel == OWNER_DATA) ? bus.data_req_i : bus.instr_req_i;
    // A response retiring this cycle frees a slot, so a full FIFO can still issue.
    can_issue = !fifo_full || bus.mem_rvalid_i;
    mem_req   = sel_req && can_issue && !reset;
    grant     = mem_req && bus.mem_gnt_i;

    case (state_q)
      IDLE: begin
        if (mem_req && !bus.mem_gnt_i) begin
          state_d = (sel == OWNER_DATA) ? LOCK_D : LOCK_I;
        end
      end
      LOCK_I, LOCK_D: begin
        // A withdrawn request drops the lock without pushing anything.
        if (grant || !sel_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_addr  = bus.instr_addr_i;
    sel_we    = 1'b0;
    sel_be    = INSTR_BE_ALL[BE_W-1:0];
    sel_wdata = '0;
    if (sel == OWNER_DATA) begin
      sel_addr  = bus.data_addr_i;
      sel_we    = bus.data_we_i;
      sel_be    = bus.data_be_i;
      sel_wdata = bus.data_wdata_i;
    end
  end

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_addr_o  = sel_addr;
  assign bus.mem_we_o    = sel_we;
  assign bus.mem_be_o    = sel_be;
  assign bus.mem_wdata_o = sel_wdata;

  assign bus.instr_gnt_o = grant && (sel == OWNER_INSTR);
  assign bus.data_gnt_o  = grant && (sel == OWNER_DATA);

  // A pop on an empty FIFO is only meaningful with a same-cycle push (bypass).
  assign fifo_pop   = bus.mem_rvalid_i && (!fifo_empty || grant);
  assign head_owner = owner_e'(fifo_head);

  assign bus.instr_rvalid_o = fifo_pop && (head_owner == OWNER_INSTR);
  assign bus.data_rvalid_o  = fifo_pop && (head_owner == OWNER_DATA);
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;

  assign resp_err_o = resp_err_q;

  obi_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (grant),
    .push_data (sel),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding_o)
  );

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb/tb_obi_mem_arbiter.sv - self-checking bench for obi_mem_arbiter
module tb_obi_mem_arbiter;
  import obi_arb_pkg::*;

  localparam int MAXO = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam logic [31:0] IADDR  = 32'h1A000080;
  localparam logic [31:0] DADDR  = 32'h20000010;
  localparam logic [31:0] DWDATA = 32'hCAFEF00D;
  localparam logic [3:0]  DBE    = 4'h3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] outstanding;
  logic       resp_err;
  int         errors = 0;
  int         checks = 0;

  obi_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  obi_mem_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .ADDR_W          (AW),
    .DATA_W          (DW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .outstanding_o (outstanding),
    .resp_err_o    (resp_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int ir, dr, we, g, rv;
    int mreq, ig, dg, irv, drv, outst, sel;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input int ir, dr, we, g, rv, mreq, ig, dg, irv, drv, outst, sel);
    vec_t v;
    v.ir = ir; v.dr = dr; v.we = we; v.g = g; v.rv = rv;
    v.mreq = mreq; v.ig = ig; v.dg = dg; v.irv = irv; v.drv = drv;
    v.outst = outst; v.sel = sel;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int ir, input int dr, input int we, input int g, input int rv,
                        input logic [31:0] rdata);
    bus.instr_req_i  = (ir != 0);
    bus.data_req_i   = (dr != 0);
    bus.data_we_i    = (we != 0);
    bus.mem_gnt_i    = (g != 0);
    bus.mem_rvalid_i = (rv != 0);
    bus.mem_rdata_i  = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_mux(input string tag, input int sel, input logic [31:0] addr_i,
                         input logic [31:0] addr_d, input logic we, input logic [3:0] be,
                         input logic [31:0] wd);
    if (sel == 0) begin
      chk({tag, " addr"}, 64'(bus.mem_addr_o), 64'(addr_i));
      chk({tag, " we"}, 64'(bus.mem_we_o), 64'd0);
      chk({tag, " be"}, 64'(bus.mem_be_o), 64'hF);
      chk({tag, " wdata"}, 64'(bus.mem_wdata_o), 64'd0);
    end else begin
      chk({tag, " addr"}, 64'(bus.mem_addr_o), 64'(addr_d));
      chk({tag, " we"}, 64'(bus.mem_we_o), 64'(we));
      chk({tag, " be"}, 64'(bus.mem_be_o), 64'(be));
      chk({tag, " wdata"}, 64'(bus.mem_wdata_o), 64'(wd));
    end
  endtask

  // Random-phase state: reference model and requester bookkeeping.
  int          q[$];
  int          held, rr, pick, preq, room, e_mreq, e_g;
  logic        pi, pd, rv, gnt;
  logic [31:0] ai, ad, wdd, rd;
  logic [3:0]  bed;
  logic        wed;

  initial begin
    bus.instr_addr_i  = IADDR;
    bus.data_addr_i   = DADDR;
    bus.data_be_i     = DBE;
    bus.data_wdata_i  = DWDATA;
    set_in(1, 1, 0, 1, 1, 32'h0);

    // Reset: every handshake output held low even with active inputs.
    #3;
    chk("rst mem_req", 64'(bus.mem_req_o), 64'd0);
    chk("rst instr_gnt", 64'(bus.instr_gnt_o), 64'd0);
    chk("rst data_gnt", 64'(bus.data_gnt_o), 64'd0);
    chk("rst instr_rvalid", 64'(bus.instr_rvalid_o), 64'd0);
    chk("rst data_rvalid", 64'(bus.data_rvalid_o), 64'd0);
    chk("rst outstanding", 64'(outstanding), 64'd0);
    chk("rst resp_err", 64'(resp_err), 64'd0);
    set_in(0, 0, 0, 0, 0, 32'h0);
    #19 reset = 1'b0;

    // ir dr we g rv | mreq ig dg irv drv outst sel
    tbl[0]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 0);  // single fetch
    tbl[2]  = mk(0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 1, 0);  // its response
    tbl[3]  = mk(1, 1, 0, 1, 0,  1, 0, 1, 0, 0, 0, 1);  // rr now points at data
    tbl[4]  = mk(1, 1, 0, 1, 1,  1, 1, 0, 0, 1, 1, 0);
    tbl[5]  = mk(1, 1, 0, 1, 1,  1, 0, 1, 1, 0, 1, 1);
    tbl[6]  = mk(1, 1, 0, 0, 1,  1, 0, 0, 0, 1, 1, 0);  // no grant -> lock instr
    tbl[7]  = mk(1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);  // held on instr
    tbl[8]  = mk(1, 1, 0, 1, 0,  1, 1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 1, 0, 1, 0,  1, 0, 1, 0, 0, 1, 1);  // data right after
    tbl[10] = mk(1, 1, 0, 1, 0,  0, 0, 0, 0, 0, 2, 0);  // full
    tbl[11] = mk(1, 1, 0, 1, 1,  1, 1, 0, 1, 0, 2, 0);  // pop re-enables issue
    tbl[12] = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 2, 0);
    tbl[13] = mk(0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);  // lock instr
    tbl[16] = mk(0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0);  // instr withdraws
    tbl[17] = mk(0, 1, 1, 1, 0,  1, 0, 1, 0, 0, 0, 1);  // data write
    tbl[18] = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 1, 0);

    for (int i = 0; i < 19; i++) begin
      next_cycle();
      set_in(tbl[i].ir, tbl[i].dr, tbl[i].we, tbl[i].g, tbl[i].rv, 32'h13 + 32'(i));
      #4;
      chk($sformatf("t%0d mem_req", i), 64'(bus.mem_req_o), 64'(tbl[i].mreq));
      chk($sformatf("t%0d instr_gnt", i), 64'(bus.instr_gnt_o), 64'(tbl[i].ig));
      chk($sformatf("t%0d data_gnt", i), 64'(bus.data_gnt_o), 64'(tbl[i].dg));
      chk($sformatf("t%0d instr_rvalid", i), 64'(bus.instr_rvalid_o), 64'(tbl[i].irv));
      chk($sformatf("t%0d data_rvalid", i), 64'(bus.data_rvalid_o), 64'(tbl[i].drv));
      chk($sformatf("t%0d outstanding", i), 64'(outstanding), 64'(tbl[i].outst));
      chk($sformatf("t%0d instr_rdata", i), 64'(bus.instr_rdata_o), 64'(32'h13 + 32'(i)));
      chk($sformatf("t%0d data_rdata", i), 64'(bus.data_rdata_o), 64'(32'h13 + 32'(i)));
      if (tbl[i].mreq != 0)
        chk_mux($sformatf("t%0d", i), tbl[i].sel, IADDR, DADDR, tbl[i].we != 0, DBE, DWDATA);
    end
    chk("tbl resp_err", 64'(resp_err), 64'd0);

    // Contention straight after reset: grants alternate I,D,I,D.
    next_cycle();
    set_in(0, 0, 0, 0, 0, 32'h0);
    #2 reset = 1'b1;
    #10 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      set_in(1, 1, 0, 1, (k > 0) ? 1 : 0, 32'h0);
      #4;
      chk($sformatf("rr%0d instr_gnt", k), 64'(bus.instr_gnt_o), 64'(k % 2 == 0));
      chk($sformatf("rr%0d data_gnt", k), 64'(bus.data_gnt_o), 64'(k % 2 == 1));
      if (k > 0) chk($sformatf("rr%0d instr_rvalid", k), 64'(bus.instr_rvalid_o),
                     64'((k - 1) % 2 == 0));
    end
    next_cycle();
    set_in(0, 0, 0, 0, 1, 32'h0);
    #4;
    chk("rr tail data_rvalid", 64'(bus.data_rvalid_o), 64'd1);

    // Spurious response: sticky error, nothing forwarded, async clear.
    next_cycle();
    set_in(0, 0, 0, 0, 1, 32'h0);
    #4;
    chk("spur outstanding", 64'(outstanding), 64'd0);
    chk("spur instr_rvalid", 64'(bus.instr_rvalid_o), 64'd0);
    chk("spur data_rvalid", 64'(bus.data_rvalid_o), 64'd0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 32'h0);
    chk("spur resp_err set", 64'(resp_err), 64'd1);
    next_cycle();
    chk("spur resp_err sticky", 64'(resp_err), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("spur resp_err async clr", 64'(resp_err), 64'd0);
    #10 reset = 1'b0;

    // Reset mid-transaction: the late response is flagged.
    next_cycle();
    set_in(1, 0, 0, 1, 0, 32'h0);
    #4;
    chk("mid instr_gnt", 64'(bus.instr_gnt_o), 64'd1);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 32'h0);
    chk("mid outstanding pre", 64'(outstanding), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid outstanding flushed", 64'(outstanding), 64'd0);
    #10 reset = 1'b0;
    next_cycle();
    set_in(0, 0, 0, 0, 1, 32'h0);
    #4;
    chk("mid late instr_rvalid", 64'(bus.instr_rvalid_o), 64'd0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 32'h0);
    chk("mid late resp_err", 64'(resp_err), 64'd1);
    #2 reset = 1'b1;
    #10 reset = 1'b0;

    // Randomized traffic against a transaction-level reference model.
    held = -1; rr = 0; q.delete();
    pi = 1'b0; pd = 1'b0; ai = '0; ad = '0; wdd = '0; bed = '0; wed = 1'b0;
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      if (!pi && $urandom_range(0, 1) == 1) begin
        pi = 1'b1; ai = $urandom;
      end
      if (!pd && $urandom_range(0, 1) == 1) begin
        pd = 1'b1; ad = $urandom; wdd = $urandom; bed = 4'($urandom); wed = 1'($urandom);
      end
      gnt = ($urandom_range(0, 9) < 6);
      rv  = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      rd  = $urandom;
      bus.instr_addr_i = ai;
      bus.data_addr_i  = ad;
      bus.data_wdata_i = wdd;
      bus.data_be_i    = bed;
      set_in(int'(pi), int'(pd), int'(wed), int'(gnt), int'(rv), rd);

      if (held >= 0)     pick = held;
      else if (pi && pd) pick = rr;
      else if (pd)       pick = 1;
      else if (pi)       pick = 0;
      else               pick = -1;
      preq   = (pick == 0) ? int'(pi) : (pick == 1) ? int'(pd) : 0;
      room   = (q.size() < MAXO || rv) ? 1 : 0;
      e_mreq = (preq != 0 && room != 0) ? 1 : 0;
      e_g    = (e_mreq != 0 && gnt) ? 1 : 0;

      #4;
      chk($sformatf("r%0d mem_req", c), 64'(bus.mem_req_o), 64'(e_mreq));
      chk($sformatf("r%0d instr_gnt", c), 64'(bus.instr_gnt_o), 64'(e_g != 0 && pick == 0));
      chk($sformatf("r%0d data_gnt", c), 64'(bus.data_gnt_o), 64'(e_g != 0 && pick == 1));
      chk($sformatf("r%0d instr_rvalid", c), 64'(bus.instr_rvalid_o), 64'(rv && q[0] == 0));
      chk($sformatf("r%0d data_rvalid", c), 64'(bus.data_rvalid_o), 64'(rv && q[0] == 1));
      chk($sformatf("r%0d outstanding", c), 64'(outstanding), 64'(q.size()));
      if (e_mreq != 0) chk_mux($sformatf("r%0d", c), pick, ai, ad, wed, bed, wdd);

      if (rv) void'(q.pop_front());
      if (e_g != 0) begin
        q.push_back(pick);
        rr   = 1 - pick;
        held = -1;
        if (pick == 0) pi = 1'b0;
        else           pd = 1'b0;
      end else if (e_mreq != 0) begin
        held = pick;
      end
    end
    chk("rand resp_err", 64'(resp_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
